udp_tx_frame_buffer: RTL and testbench
======================================

Name: udp_tx_frame_buffer

Overview:
- Store-and-forward payload buffer directly upstream of the UDP/IP/Ethernet transmit chain; its master stream drives that chain's s_axis input.
- Accepts raw UDP payload bytes as an AXI-Stream, holds each frame until complete, and drops oversized or errored frames.
- For the frame being sent, drives UDP_TotLen and IP_TotLen so header generation always has exact lengths before the first byte leaves.

Parameters:
- ADDR_WIDTH, 11, byte RAM depth = 2**ADDR_WIDTH; must satisfy 2**ADDR_WIDTH >= MAX_LEN.
- MAX_LEN, 1472, largest legal payload in bytes; longer frames are dropped.
- LEN_DEPTH_LOG2, 2, committed-frame length queue depth = 2**LEN_DEPTH_LOG2.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  error flag; sampled on the tlast beat; 1 = discard frame.
- s_axis_tready  out  1  buffer accepts a byte.
- m_axis_tdata  out  8  payload byte to the transmit chain.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tlast  out  1  last byte of frame.
- m_axis_tuser  out  1  start of frame; high on the first byte only.
- m_axis_tready  in  1  downstream accepts a byte.
- UDP_TotLen  out  16  payload length + 8; stable while len_valid is high.
- IP_TotLen  out  16  payload length + 28; stable while len_valid is high.
- len_valid  out  1  lengths valid for the frame currently being sent.
- frame_drop  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, len_valid=0, UDP_TotLen=0, IP_TotLen=0, frame_drop=0. All pointers, counts and the queue clear.
- s_axis_tready rises the first cycle after rst deasserts, subject to the write rules below.
- Reset mid-operation discards every stored and partial frame. All outputs take their reset values on the next edge.
- Write side:
  - Beat = s_axis_tvalid & s_axis_tready.
  - A 16-bit wr_cnt counts bytes of the current frame.
  - While wr_cnt < MAX_LEN, the byte is written at wr_ptr and wr_ptr increments, wrapping mod 2**ADDR_WIDTH.
  - Once wr_cnt reaches MAX_LEN, the frame is overlong: further bytes are accepted but not written.
  - s_axis_tready = (RAM not full) & (len queue not full), or 1 while overlong.
- tlast beat:
  - Commit if tuser=0 and not overlong. wr_base advances to the new wr_ptr, and wr_cnt (including this byte) is pushed to the len queue.
  - Otherwise drop: wr_ptr rewinds to wr_base and frame_drop pulses the next cycle.
  - wr_cnt resets to 0 in both cases.
- RAM full = (wr_ptr - rd_ptr) mod depth == depth-1. Free space counts from rd_ptr, not from committed data.
- Read FSM, four states:
  - IDLE: when the queue is non-empty, pop the length into rd_len, compute UDP_TotLen=rd_len+8 and IP_TotLen=rd_len+28, assert len_valid, issue the RAM read. Go to PREF.
  - PREF: RAM data (1-cycle read latency) is loaded into the output register. m_axis_tvalid=1 and m_axis_tuser=1. m_axis_tlast=1 if rd_len==1. Go to SEND.
  - SEND: on each m_axis handshake, advance rd_ptr and present the next byte with no bubbles, using a prefetched read. tuser drops after the first handshake; tlast is high on byte rd_len. On the tlast handshake, go to DONE.
  - DONE: deassert m_axis_tvalid and len_valid. Go to IDLE, which gives at least one idle cycle between frames.
- Data and tvalid hold while m_axis_tready=0 (AXI rule).
- Latency: a frame's first byte appears at most 3 cycles after its tlast write, if the reader is IDLE.
- Simultaneous commit and queue pop in the same cycle are both honoured; the count stays consistent.
- A tlast beat arriving when the queue is full cannot occur, because tready is already low.
- Minimum frame is 1 byte; zero-length frames are not representable.

Decomposition:
- Shared package holds the header size constants: UDP_HDR_LEN=8, IP_HDR_LEN=20, IP_UDP_HDR_LEN=28.
- Shared package holds the FSM state encoding and the default MAX_LEN=1472.
- One sub-module, sdp_byte_ram: simple dual-port RAM, 1 write and 1 read port, synchronous read, 1-cycle latency. Parameterised on ADDR_WIDTH.
- The length queue is a small inline register FIFO.

Test Plan:
- Single 18-byte frame 0x00..0x11, m_axis_tready=1 → 18 bytes out in order; tuser on 0x00, tlast on 0x11; UDP_TotLen=26, IP_TotLen=46, len_valid high for the whole frame.
- 1473-byte frame, then a 4-byte frame → frame_drop pulses once after byte 1473. Only the 4-byte frame is sent, with UDP_TotLen=12 and IP_TotLen=32; no deadlock.
- 10-byte frame with s_axis_tuser=1 on tlast → frame_drop pulses, nothing output, wr_ptr back to its prior value. The next frame is sent intact.
- Four back-to-back 1472-byte frames with m_axis_tready held low → s_axis_tready falls when the RAM or queue is full. After tready is released, all frames emerge intact with no byte loss, including across the RAM wrap boundary.
- Random m_axis_tready toggling on a 64-byte frame → tdata and tlast stay stable while stalled. Output matches input, with exactly one tuser and one tlast.
- rst asserted mid-send of a 100-byte frame → next cycle m_axis_tvalid=0 and len_valid=0. After reset, a new 5-byte frame outputs correctly with no residue.

Source files
------------

// File: rtl/udp_tx_frame_buffer_pkg.sv
// Shared constants and read-FSM encoding for the UDP transmit frame buffer.
// Header sizes feed the length fields handed to the UDP/IP header generator.
package udp_tx_frame_buffer_pkg;

  localparam int UDP_HDR_LEN     = 8;
  localparam int IP_HDR_LEN      = 20;
  localparam int IP_UDP_HDR_LEN  = UDP_HDR_LEN + IP_HDR_LEN;
  localparam int DEFAULT_MAX_LEN = 1472;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PREF,
    RD_SEND,
    RD_DONE
  } rd_state_t;

endpackage

// File: rtl/udp_tx_frame_buffer_sdp_byte_ram.sv
// Simple dual-port byte RAM: one write port, one read port.
// Reads are synchronous with one cycle of latency; read data holds while re is low.
module sdp_byte_ram
  import udp_tx_frame_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_tx_frame_buffer.sv
// Store-and-forward UDP payload buffer: holds each frame until complete, drops
// oversized or errored frames, and publishes exact lengths before sending.
module udp_tx_frame_buffer
  import udp_tx_frame_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int MAX_LEN        = DEFAULT_MAX_LEN,
  parameter int LEN_DEPTH_LOG2 = 2
) (
  input  logic        s_axis_aclk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [15:0] UDP_TotLen,
  output logic [15:0] IP_TotLen,
  output logic        len_valid,
  output logic        frame_drop
);

  localparam int Q_DEPTH = 2**LEN_DEPTH_LOG2;
  localparam int QW      = LEN_DEPTH_LOG2 + 1;
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  logic                      run;
  logic [ADDR_WIDTH-1:0]     wr_ptr, wr_base, rd_ptr, fill_level, ram_raddr;
  logic [15:0]               wr_cnt, rd_len, out_cnt;
  logic [15:0]               len_q [Q_DEPTH];
  logic [LEN_DEPTH_LOG2-1:0] q_wr_idx, q_rd_idx;
  logic [QW-1:0]             q_count;
  logic                      overlong, ram_full, q_full, beat, ram_we;
  logic                      commit, drop, pop, ram_re, hs;
  logic [7:0]                ram_rdata;
  rd_state_t                 state, state_nxt;

  assign fill_level    = wr_ptr - rd_ptr;
  assign ram_full      = fill_level == {ADDR_WIDTH{1'b1}};
  assign q_full        = q_count == QW'(Q_DEPTH);
  assign overlong      = wr_cnt >= MAX_LEN16;
  assign s_axis_tready = run & (overlong | (~ram_full & ~q_full));
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign ram_we        = beat & ~overlong;
  assign commit        = beat & s_axis_tlast & ~s_axis_tuser & ~overlong;
  assign drop          = beat & s_axis_tlast & ~commit;
  assign hs            = m_axis_tvalid & m_axis_tready;

  sdp_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (s_axis_aclk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (s_axis_tdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Write side: a dropped frame rewinds to the last committed boundary.
  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      run        <= 1'b0;
      wr_ptr     <= '0;
      wr_base    <= '0;
      wr_cnt     <= '0;
      frame_drop <= 1'b0;
    end else begin
      run        <= 1'b1;
      frame_drop <= drop;
      if (beat) begin
        if (s_axis_tlast) begin
          wr_cnt <= '0;
          if (commit) begin
            wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
            wr_base <= wr_ptr + ADDR_WIDTH'(1);
          end else begin
            wr_ptr <= wr_base;
          end
        end else if (!overlong) begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
          wr_cnt <= wr_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (commit) len_q[q_wr_idx] <= wr_cnt + 16'd1;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      q_wr_idx <= '0;
      q_rd_idx <= '0;
      q_count  <= '0;
    end else begin
      if (commit) q_wr_idx <= q_wr_idx + LEN_DEPTH_LOG2'(1);
      if (pop)    q_rd_idx <= q_rd_idx + LEN_DEPTH_LOG2'(1);
      unique case ({commit, pop})
        2'b10:   q_count <= q_count + QW'(1);
        2'b01:   q_count <= q_count - QW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  // The RAM always runs one byte ahead of the output register in SEND.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = rd_ptr;
    unique case (state)
      RD_IDLE: begin
        if (q_count != '0) begin
          pop       = 1'b1;
          ram_re    = 1'b1;
          state_nxt = RD_PREF;
        end
      end
      RD_PREF: begin
        ram_re    = 1'b1;
        ram_raddr = rd_ptr + ADDR_WIDTH'(1);
        state_nxt = RD_SEND;
      end
      RD_SEND: begin
        if (hs) begin
          if (m_axis_tlast) begin
            state_nxt = RD_DONE;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = rd_ptr + ADDR_WIDTH'(2);
          end
        end
      end
      RD_DONE: state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      rd_ptr        <= '0;
      rd_len        <= '0;
      out_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      len_valid     <= 1'b0;
      UDP_TotLen    <= '0;
      IP_TotLen     <= '0;
    end else begin
      unique case (state)
        RD_IDLE: begin
          if (pop) begin
            rd_len     <= len_q[q_rd_idx];
            UDP_TotLen <= len_q[q_rd_idx] + 16'(UDP_HDR_LEN);
            IP_TotLen  <= len_q[q_rd_idx] + 16'(IP_UDP_HDR_LEN);
            len_valid  <= 1'b1;
          end
        end
        RD_PREF: begin
          m_axis_tdata  <= ram_rdata;
          m_axis_tvalid <= 1'b1;
          m_axis_tuser  <= 1'b1;
          m_axis_tlast  <= rd_len == 16'd1;
          out_cnt       <= 16'd1;
        end
        RD_SEND: begin
          if (hs) begin
            rd_ptr       <= rd_ptr + ADDR_WIDTH'(1);
            m_axis_tuser <= 1'b0;
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              len_valid     <= 1'b0;
            end else begin
              m_axis_tdata <= ram_rdata;
              m_axis_tlast <= (out_cnt + 16'd1) == rd_len;
              out_cnt      <= out_cnt + 16'd1;
            end
          end
        end
        RD_DONE: begin
          m_axis_tvalid <= 1'b0;
          len_valid     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_frame_buffer.sv
// Self-checking bench for udp_tx_frame_buffer: random frames go in, and a queue
// model of committed frames predicts every output byte, flag and length.
module tb_udp_tx_frame_buffer;

  localparam int MAX_LEN = 1472;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic [15:0] UDP_TotLen;
  logic [15:0] IP_TotLen;
  logic        len_valid;
  logic        frame_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int out_pos = 0;
  int exp_drops = 0;
  int drops_seen = 0;
  int tlast_cyc = 0;
  int sof_cyc = 0;

  // {tuser, tlast, data} per input beat, and the committed-frame model.
  logic [9:0] tx_q[$];
  logic [7:0] exp_byte_q[$];
  int         exp_len_q[$];

  udp_tx_frame_buffer dut (
    .s_axis_aclk   (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .UDP_TotLen    (UDP_TotLen),
    .IP_TotLen     (IP_TotLen),
    .len_valid     (len_valid),
    .frame_drop    (frame_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int len, input bit err, input bit incr);
    logic [7:0] d;
    logic       last;
    logic       tu;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      d    = incr ? 8'(i) : 8'($urandom);
      tu   = last ? err : 1'($urandom);
      tx_q.push_back({tu, last, d});
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (tx_q.size() == 0 && exp_len_q.size() == 0 && !m_axis_tvalid) begin
        done = 1;
        break;
      end
    end
    checkOutput("drain_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Sender: drives queued beats with random gaps; on each accepted tlast the
  // model decides whether the frame is committed or dropped.
  initial begin
    logic [9:0] ent;
    logic [7:0] frame_bytes[$];
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_q.size() != 0 && !rst) begin
        ent = tx_q[0];
        s_axis_tvalid = ($urandom_range(0, 5) != 0);
        {s_axis_tuser, s_axis_tlast, s_axis_tdata} = ent;
        @(negedge clk);
        if (s_axis_tvalid && s_axis_tready) begin
          void'(tx_q.pop_front());
          frame_bytes.push_back(ent[7:0]);
          if (ent[8]) begin
            tlast_cyc = cyc;
            if (frame_bytes.size() <= MAX_LEN && !ent[9]) begin
              foreach (frame_bytes[k]) exp_byte_q.push_back(frame_bytes[k]);
              exp_len_q.push_back(frame_bytes.size());
            end else begin
              exp_drops++;
            end
            frame_bytes = {};
          end
        end
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
  end

  // Monitor: checks every output handshake against the model and AXI hold rules.
  initial begin
    bit         prev_stall;
    bit         prev_valid;
    logic [7:0] prev_data;
    logic       prev_last;
    int         flen;
    prev_stall = 0;
    prev_valid = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_pos    = 0;
        prev_stall = 0;
        prev_valid = 0;
      end else begin
        if (frame_drop) drops_seen++;
        if (prev_stall) begin
          checkOutput("hold_valid", 32'(m_axis_tvalid), 32'd1);
          checkOutput("hold_data", 32'(m_axis_tdata), 32'(prev_data));
          checkOutput("hold_last", 32'(m_axis_tlast), 32'(prev_last));
        end
        if (m_axis_tvalid && !prev_valid && m_axis_tuser) sof_cyc = cyc;
        prev_valid = m_axis_tvalid;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
          checkOutput("beat_expected", 32'(exp_len_q.size() != 0), 32'd1);
          if (exp_len_q.size() != 0) begin
            flen = exp_len_q[0];
            checkOutput("data", 32'(m_axis_tdata), 32'(exp_byte_q[0]));
            checkOutput("tuser", 32'(m_axis_tuser), 32'(out_pos == 0));
            checkOutput("tlast", 32'(m_axis_tlast), 32'(out_pos == flen - 1));
            checkOutput("len_valid", 32'(len_valid), 32'd1);
            checkOutput("udp_len", 32'(UDP_TotLen), 32'(flen + 8));
            checkOutput("ip_len", 32'(IP_TotLen), 32'(flen + 28));
            void'(exp_byte_q.pop_front());
            out_pos++;
            if (out_pos == flen) begin
              void'(exp_len_q.pop_front());
              out_pos = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    bit reached;
    rst = 1'b1;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
    checkOutput("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    checkOutput("rst_len_valid", 32'(len_valid), 32'd0);
    checkOutput("rst_udp_len", 32'(UDP_TotLen), 32'd0);
    checkOutput("rst_ip_len", 32'(IP_TotLen), 32'd0);
    checkOutput("rst_frame_drop", 32'(frame_drop), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(s_axis_tready), 32'd1);

    $display("[TB] 18-byte counting frame");
    applyStimulus(18, 1'b0, 1'b1);
    wait_idle(400);
    checkOutput("first_byte_latency", 32'((sof_cyc - tlast_cyc) <= 3), 32'd1);
    checkOutput("drops_single", 32'(drops_seen), 32'd0);

    $display("[TB] overlong 1473-byte frame then 4-byte frame");
    applyStimulus(1473, 1'b0, 1'b0);
    applyStimulus(4, 1'b0, 1'b1);
    wait_idle(4000);
    checkOutput("drops_overlong", 32'(drops_seen), 32'd1);

    $display("[TB] errored 10-byte frame then clean frame");
    applyStimulus(10, 1'b1, 1'b1);
    applyStimulus(7, 1'b0, 1'b0);
    wait_idle(500);
    checkOutput("drops_err", 32'(drops_seen), 32'd2);

    $display("[TB] four max-length frames against a stalled sink");
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) applyStimulus(MAX_LEN, 1'b0, 1'b0);
    repeat (3000) @(posedge clk);
    @(negedge clk);
    checkOutput("ram_full_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("stalled_tvalid", 32'(m_axis_tvalid), 32'd1);
    rdy_mode = 0;
    wait_idle(12000);

    $display("[TB] short frames filling the length queue");
    rdy_mode = 2;
    applyStimulus(1, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) applyStimulus($urandom_range(1, 3), 1'b0, 1'b0);
    repeat (80) @(posedge clk);
    @(negedge clk);
    checkOutput("queue_full_tready", 32'(s_axis_tready), 32'd0);
    rdy_mode = 0;
    wait_idle(500);

    $display("[TB] 64-byte frame with random sink stalls");
    rdy_mode = 1;
    applyStimulus(64, 1'b0, 1'b0);
    wait_idle(1000);

    $display("[TB] random frames");
    for (int f = 0; f < 15; f++)
      applyStimulus($urandom_range(1, 200), ($urandom_range(0, 7) == 0), 1'b0);
    wait_idle(20000);
    checkOutput("drops_model", 32'(drops_seen), 32'(exp_drops));

    $display("[TB] reset during a 100-byte frame");
    rdy_mode = 0;
    applyStimulus(100, 1'b0, 1'b1);
    reached = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (out_pos >= 30) begin
        reached = 1;
        break;
      end
    end
    checkOutput("mid_frame_reached", 32'(reached), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_byte_q = {};
    exp_len_q  = {};
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("midrst_len_valid", 32'(len_valid), 32'd0);
    checkOutput("midrst_s_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(5, 1'b0, 1'b1);
    wait_idle(300);
    checkOutput("drops_final", 32'(drops_seen), 32'(exp_drops));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
